// File: rtl/yuv_packer_pkg.sv
// Shared types and constants for the YUYV stream packer.
package yuv_packer_pkg;

  localparam int PIX_W    = 16;
  localparam int WORD_PIX = 4;
  localparam int WORD_W   = PIX_W * WORD_PIX;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} packer_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sof;
    logic              eof;
  } packed_word_t;

  function automatic logic mask_legal(input logic [3:0] m);
    return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
  endfunction

  function automatic logic [2:0] mask_count(input logic [3:0] m);
    case (m)
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b1111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/yuv_pack_fifo.sv
// Synchronous FIFO of packed words; a push when full succeeds only alongside a pop.
module yuv_pack_fifo
  import yuv_packer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     pixel_clk_i,
  input  logic                     reset_i,
  input  logic                     push,
  input  packed_word_t             push_word,
  input  logic                     pop,
  output packed_word_t             pop_word,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  packed_word_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_word = mem[rd_ptr];

  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // storage has no reset; occupancy is tracked by count
  always_ff @(posedge pixel_clk_i) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: rtl/yuv_stream_packer.sv
// Packs 1/2/4-pixel YUYV beats into 64-bit words with SOF/EOF tags and buffers them.
//
// state  | meaning
// IDLE   | no frame; pixels here are protocol errors
// ACTIVE | accumulating pixels, pushing the staged word as each new word completes
// FLUSH  | frame ended; drain staged word then partial word, then count the frame
module yuv_stream_packer
  import yuv_packer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_THRESH = 5,
  parameter int FCNT_W       = 16
) (
  input  logic              pixel_clk_i,
  input  logic              reset_i,
  input  logic              frame_valid_i,
  input  logic [63:0]       yuv_data_i,
  input  logic [3:0]        yuv_data_valid_i,
  output logic [63:0]       m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_sof_o,
  output logic              m_eof_o,
  output logic              stall_o,
  output logic              overflow_o,
  output logic              proto_err_o,
  output logic [FCNT_W-1:0] frame_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  packer_state_t     state_q, state_d;
  logic [47:0]       acc_q, acc_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [63:0]       stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic              sof_pend_q, sof_pend_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              stall_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
  packed_word_t      push_word, pop_word;
  logic [AW:0]       fifo_count;

  logic              mask_ok, pix_seen;
  logic [2:0]        n_pix, total;
  logic [63:0]       pix_mask;
  logic [111:0]      merged;

  assign mask_ok  = mask_legal(yuv_data_valid_i);
  assign pix_seen = |yuv_data_valid_i;
  assign n_pix    = mask_count(yuv_data_valid_i);
  assign total    = {1'b0, acc_cnt_q} + n_pix;
  assign pix_mask = {{16{yuv_data_valid_i[3]}}, {16{yuv_data_valid_i[2]}},
                     {16{yuv_data_valid_i[1]}}, {16{yuv_data_valid_i[0]}}};
  // new pixels land directly above the ones already held; unused slots stay zero
  assign merged   = {64'b0, acc_q} | ({48'b0, yuv_data_i & pix_mask} << {acc_cnt_q, 4'b0000});

  assign fifo_pop = m_ready_i && !fifo_empty;
  assign can_push = !fifo_full || fifo_pop;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    sof_pend_d  = sof_pend_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q || !mask_ok;
    fcnt_d      = fcnt_q;
    fifo_push   = 1'b0;
    push_word   = '0;
    case (state_q)
      IDLE: begin
        if (pix_seen) perr_d = 1'b1;
        if (frame_valid_i) begin
          state_d    = ACTIVE;
          sof_pend_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (mask_ok && pix_seen) begin
          if (total >= 3'd4) begin
            if (stage_vld_q) begin
              fifo_push      = 1'b1;
              push_word.data = stage_q;
              push_word.sof  = sof_pend_q;
              sof_pend_d     = 1'b0;
              if (!can_push) ovf_d = 1'b1;
            end
            stage_d     = merged[63:0];
            stage_vld_d = 1'b1;
            acc_d       = merged[111:64];
            acc_cnt_d   = total[1:0];
          end else begin
            acc_d     = merged[47:0];
            acc_cnt_d = total[1:0];
          end
        end
        if (!frame_valid_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (pix_seen) perr_d = 1'b1;
        if (stage_vld_q) begin
          fifo_push      = 1'b1;
          push_word.data = stage_q;
          push_word.sof  = sof_pend_q;
          push_word.eof  = (acc_cnt_q == 2'd0);
          if (can_push) begin
            stage_vld_d = 1'b0;
            sof_pend_d  = 1'b0;
          end
        end else if (acc_cnt_q != 2'd0) begin
          fifo_push      = 1'b1;
          push_word.data = {16'b0, acc_q};
          push_word.sof  = sof_pend_q;
          push_word.eof  = 1'b1;
          if (can_push) begin
            acc_d      = '0;
            acc_cnt_d  = '0;
            sof_pend_d = 1'b0;
          end
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (frame_valid_i) begin
            state_d    = ACTIVE;
            sof_pend_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      fcnt_q      <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      sof_pend_q  <= sof_pend_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      fcnt_q      <= fcnt_d;
      stall_q     <= (fifo_count >= (AW+1)'(AFULL_THRESH));
    end
  end

  yuv_pack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pixel_clk_i (pixel_clk_i),
    .reset_i     (reset_i),
    .push        (fifo_push),
    .push_word   (push_word),
    .pop         (fifo_pop),
    .pop_word    (pop_word),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // stale storage is masked so outputs read zero while the FIFO is empty
  assign m_valid_o     = !fifo_empty;
  assign m_data_o      = fifo_empty ? '0 : pop_word.data;
  assign m_sof_o       = !fifo_empty && pop_word.sof;
  assign m_eof_o       = !fifo_empty && pop_word.eof;
  assign stall_o       = stall_q;
  assign overflow_o    = ovf_q;
  assign proto_err_o   = perr_q;
  assign frame_count_o = fcnt_q;

endmodule
